// File: rtl/descramble_pkg.sv
// Shared constants, FSM state type and key-validity helper for the address
// descrambler.
package descramble_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned KEY_W  = 16;
    localparam int unsigned TAP_W  = 4;
    localparam int unsigned N_TAPS = KEY_W / TAP_W;
    localparam int unsigned CNT_W  = 5;

    localparam logic [TAP_W-1:0] MSB_TAP = TAP_W'(11);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // A key is invertible only if every tap addresses a real bit and the MSB
    // appears an odd number of times (pairs of MSB taps cancel out).
    function automatic logic key_is_valid(input logic [KEY_W-1:0] key);
        logic             in_range;
        logic             msb_odd;
        logic [TAP_W-1:0] tap;
        in_range = 1'b1;
        msb_odd  = 1'b0;
        for (int unsigned i = 0; i < N_TAPS; i++) begin
            tap = key[i*TAP_W +: TAP_W];
            if (tap > MSB_TAP) in_range = 1'b0;
            if (tap == MSB_TAP) msb_odd = ~msb_odd;
        end
        return in_range & msb_odd;
    endfunction

endpackage

// File: rtl/descramble_lfsr_inv_step.sv
// One inverse step of the keyed 12-bit LFSR scrambler.
// Forward step: s' = {s[10:0], s[k4]^s[k3]^s[k2]^s[k1]}.
// Inverse: the low bits shift back down, and s[11] is rebuilt from the
// feedback bit s'[0] by removing every non-MSB tap contribution s'[k+1].
// Taps above the MSB read as 0 so an illegal key never produces X.
module lfsr_inv_step
    import descramble_pkg::*;
(
    input  logic [ADDR_W-1:0] state_i,
    input  logic [KEY_W-1:0]  key_i,
    output logic [ADDR_W-1:0] state_o
);

    logic             fb;
    logic [TAP_W-1:0] tap;

    // Recover the bit that was shifted out of the MSB on the forward step.
    always_comb begin
        fb  = state_i[0];
        tap = '0;
        for (int unsigned i = 0; i < N_TAPS; i++) begin
            tap = key_i[i*TAP_W +: TAP_W];
            if (tap < MSB_TAP) fb = fb ^ state_i[tap + 1'b1];
        end
    end

    assign state_o = {fb, state_i[ADDR_W-1:1]};

endmodule

// File: rtl/descramble.sv
// Iterative address descrambler: accepts a scrambled address and tap key,
// runs ROUNDS inverse LFSR steps (one per cycle) and presents the plain
// address with a valid/ready handshake on both sides.
// Optional build macro: DESCRAMBLE_KEY_CHECK_EN -- non-invertible keys skip
// the rounds and return the input unchanged with key_err set.
module descramble
    import descramble_pkg::*;
#(
    parameter int unsigned ROUNDS = 12
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [KEY_W-1:0]  key,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              key_err
);

    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] work_q;
    logic [ADDR_W-1:0] work_d;
    logic [KEY_W-1:0]  key_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              key_err_q;
    logic              key_bad;

`ifdef DESCRAMBLE_KEY_CHECK_EN
    assign key_bad = ~key_is_valid(key);
`else
    assign key_bad = 1'b0;
`endif

    lfsr_inv_step u_step (
        .state_i (work_q),
        .key_i   (key_q),
        .state_o (work_d)
    );

    // Control FSM with registered handshake outputs; the work register is
    // updated from the step logic while running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            key_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_q      <= in_addr;
                        key_q       <= key;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b0;
                        key_err_q   <= key_bad;
                        out_valid_q <= key_bad;
                        state_q     <= key_bad ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_RND) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_addr  = work_q;
    assign key_err   = key_err_q;

endmodule
